urv_fetch_unit: RTL and testbench
=================================

Name: urv_fetch_unit

Overview:
- Fetch stage of the uRV pipeline, directly upstream of instruction decode.
- Generates the instruction-memory address stream and registers the returned instruction word with its PC.
- Presents f_ir_o / f_pc_o / f_valid_o to decode.
- Absorbs decode back-pressure with a 1-entry skid buffer; handles branch/exception redirects from execute by discarding in-flight fetches.

Parameters:
RESET_VECTOR, 32'h00000000, PC of the first instruction fetched after reset.

Ports:
clk_i  in  1  clock, all state on rising edge
rst_n_i  in  1  asynchronous active-low reset
f_stall_i  in  1  decode cannot accept; hold f_* outputs
f_kill_i  in  1  redirect: flush fetch and restart at f_bra_target_i
f_bra_target_i  in  32  redirect PC, bits [1:0] ignored (treated as 0)
im_addr_o  out  32  next fetch address (combinational), word aligned
im_rd_o  out  1  im_addr_o is a real request this cycle
im_data_i  in  32  instruction word for the previously sampled request
im_valid_i  in  1  im_data_i valid; low = memory busy, request must be retried
f_ir_o  out  32  registered instruction to decode
f_pc_o  out  32  registered PC of f_ir_o
f_valid_o  out  1  f_ir_o/f_pc_o hold a live instruction

Behaviour:
- Memory protocol:
  - Memory samples im_addr_o at the rising edge of any cycle with im_rd_o=1.
  - The response appears in the next cycle, qualified by im_valid_i.
  - If im_valid_i=0 in the response cycle, the request is lost; the same address is re-presented with im_rd_o=1.
  - At most one request is in flight.
- State:
  - pc_req: address of the in-flight request.
  - pending: a request is in flight.
  - discard: the in-flight response belongs to a killed path.
  - skid_valid, skid_ir, skid_pc: 1-entry skid buffer.
- FSM:
  - BOOT: first cycle after reset. im_rd_o=1, im_addr_o=RESET_VECTOR → RUN.
  - RUN: normal streaming.
  - HOLD: skid full, waiting for f_stall_i to fall.
- Reset (asynchronous, rst_n_i=0):
  - f_valid_o=0, f_ir_o=32'h00000013 (NOP), f_pc_o=0.
  - pending=0, discard=0, skid_valid=0.
  - pc_req=RESET_VECTOR, state BOOT.
  - Reset mid-operation drops any in-flight response; no output update until BOOT re-runs.
- Response accept: the cycle has pending=1, im_valid_i=1 and discard=0.
- Next address (combinational):
  - pc_req+4 if a response is accepted.
  - pc_req if pending && !im_valid_i (retry).
  - f_bra_target_i if f_kill_i.
  - 32-bit wrap-around on +4 (32'hFFFFFFFC → 0), no flag.
- im_rd_o:
  - 1 in BOOT and RUN when !(f_stall_i && pending) and !skid_valid.
  - Otherwise 0, so at most one response can arrive during a stall.
- Output register, when !f_stall_i:
  - If skid_valid: load skid contents, set f_valid_o=1, clear skid_valid, HOLD→RUN.
  - Else if a response is accepted: f_ir_o=im_data_i, f_pc_o=pc_req, f_valid_o=1.
  - Else f_valid_o=0.
- Output register, when f_stall_i: f_* outputs hold. An accepted response goes to the skid (skid_valid=1, →HOLD).
- Redirect (f_kill_i=1), highest priority, overrides stall:
  - Next edge: f_valid_o=0, skid_valid=0.
  - discard=pending (the in-flight request is dropped when it returns).
  - Target request issued in the kill cycle via combinational im_addr_o.
  - First valid instruction from the target reaches f_valid_o 2 cycles after the kill cycle if the memory responds with no wait states.
  - A kill on the same cycle as a response: the response is dropped.
- discard clears at the edge where its response (im_valid_i=1) returns, or immediately if no request is pending.
- Throughput: 1 instruction/cycle with zero-wait memory and no stall. Each memory wait cycle inserts one bubble.
- No instruction is duplicated or lost across stall, wait, or kill combinations, except instructions deliberately flushed by kill.

Test Plan:
- Reset release with RESET_VECTOR=0, zero-wait memory returning data=addr → im_addr_o 0,4,8,…; f_valid_o rises 2 cycles after BOOT, f_pc_o=0 with f_ir_o=0, then 4/4, 8/8 every cycle.
- f_stall_i held 3 cycles while streaming at pc 0x10 → f_pc_o stays 0x10, skid captures 0x14, im_rd_o=0 during stall; after release outputs 0x14 then 0x18 with no gap and no duplicate.
- im_valid_i low for 2 cycles on request 0x20 → 0x20 re-presented twice, two bubbles on f_valid_o, then f_pc_o=0x20 with correct data.
- f_kill_i with target 0x100 while 0x30 is in flight, and again during a stall with skid full → 0x30 and skid contents never appear on f_valid_o; next valid f_pc_o=0x100 two cycles after kill.
- pc_req=0xFFFFFFFC streaming → next im_addr_o=0x00000000, f_pc_o sequence FFFFFFFC, 00000000.
- rst_n_i asserted asynchronously mid-stream with a response pending → f_valid_o=0 immediately; after release the first f_pc_o is RESET_VECTOR; the stale response is ignored.

Source files
------------

// File: rtl/urv_fetch_unit.sv
// urv_fetch_unit: instruction fetch stage of the uRV pipeline.
// Drives the instruction-memory address stream (one request in flight),
// registers each returned word together with its PC for decode, absorbs
// decode stalls with a single-entry skid buffer and restarts on redirects.
module urv_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        f_stall_i,
  input  logic        f_kill_i,
  input  logic [31:0] f_bra_target_i,
  output logic [31:0] im_addr_o,
  output logic        im_rd_o,
  input  logic [31:0] im_data_i,
  input  logic        im_valid_i,
  output logic [31:0] f_ir_o,
  output logic [31:0] f_pc_o,
  output logic        f_valid_o
);

  localparam logic [1:0]  ST_BOOT  = 2'd0;
  localparam logic [1:0]  ST_RUN   = 2'd1;
  localparam logic [1:0]  ST_HOLD  = 2'd2;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic [31:0] BOOT_PC  = RESET_VECTOR & 32'hFFFF_FFFC;

  logic [1:0]  state_q,      state_d;
  logic [31:0] pc_req_q,     pc_req_d;
  logic        pending_q,    pending_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_ir_q,    skid_ir_d;
  logic [31:0] skid_pc_q,    skid_pc_d;
  logic [31:0] f_ir_q,       f_ir_d;
  logic [31:0] f_pc_q,       f_pc_d;
  logic        f_valid_q,    f_valid_d;

  logic        accept;
  logic [31:0] kill_pc;
  logic [31:0] next_addr;
  logic        issue;

  // The response to a request always arrives in the cycle right after it
  // was sampled, so whatever was in flight when a kill arrives returns in
  // that same kill cycle. Gating acceptance with f_kill_i therefore drops
  // every killed-path response; the request issued in the kill cycle is
  // already for the target and must be kept.
  assign accept  = pending_q & im_valid_i & ~f_kill_i;
  assign kill_pc = f_bra_target_i & 32'hFFFF_FFFC;

  // Next fetch address: redirect, then sequential advance, else retry/hold.
  // While nothing is pending, pc_req_q holds the next address still to
  // be fetched, so the last branch covers both retry and resume.
  always_comb begin
    if (f_kill_i) begin
      next_addr = kill_pc;
    end else if (accept) begin
      next_addr = pc_req_q + 32'd4;
    end else begin
      next_addr = pc_req_q;
    end
  end

  // Request enable: while decode stalls, stop issuing once a response is
  // due or the skid is occupied, so at most one word lands in the skid.
  // When the stall drops with the skid full, fetch resumes in the same
  // cycle the skid drains so the stream continues without a bubble.
  assign issue = f_kill_i
               | (state_q == ST_BOOT)
               | ~f_stall_i
               | (~pending_q & ~skid_valid_q);

  assign im_addr_o = next_addr;
  assign im_rd_o   = issue;

  // Request tracking: every issued address becomes the in-flight one; an
  // unissued address is remembered for the next attempt.
  always_comb begin
    pc_req_d  = next_addr;
    pending_d = issue;
  end

  // Output register, skid buffer and FSM next state.
  always_comb begin
    // NOTE: every signal gets a hold default before any branch; a path that
    // leaves one unassigned would infer a latch instead of a register input.
    f_ir_d       = f_ir_q;
    f_pc_d       = f_pc_q;
    f_valid_d    = f_valid_q;
    skid_valid_d = skid_valid_q;
    skid_ir_d    = skid_ir_q;
    skid_pc_d    = skid_pc_q;

    if (f_kill_i) begin
      f_valid_d    = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!f_stall_i) begin
      if (skid_valid_q) begin
        f_ir_d       = skid_ir_q;
        f_pc_d       = skid_pc_q;
        f_valid_d    = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        f_ir_d    = im_data_i;
        f_pc_d    = pc_req_q;
        f_valid_d = 1'b1;
      end else begin
        f_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_ir_d    = im_data_i;
      skid_pc_d    = pc_req_q;
      skid_valid_d = 1'b1;
    end

    // BOOT lasts a single cycle; HOLD is exactly "skid occupied".
    state_d = skid_valid_d ? ST_HOLD : ST_RUN;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_BOOT;
      pc_req_q     <= BOOT_PC;
      pending_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      // NOTE: the skid payload is reset too even though skid_valid_q guards
      // it; it is only 64 flops and keeps X out of the output register.
      skid_ir_q    <= NOP_INSN;
      skid_pc_q    <= 32'h0000_0000;
      f_ir_q       <= NOP_INSN;
      f_pc_q       <= 32'h0000_0000;
      f_valid_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the pre-edge state, independent of statement order.
      state_q      <= state_d;
      pc_req_q     <= pc_req_d;
      pending_q    <= pending_d;
      skid_valid_q <= skid_valid_d;
      skid_ir_q    <= skid_ir_d;
      skid_pc_q    <= skid_pc_d;
      f_ir_q       <= f_ir_d;
      f_pc_q       <= f_pc_d;
      f_valid_q    <= f_valid_d;
    end
  end

  assign f_ir_o    = f_ir_q;
  assign f_pc_o    = f_pc_q;
  assign f_valid_o = f_valid_q;

endmodule

// File: tb/tb_urv_fetch_unit.sv
// tb_urv_fetch_unit: self-checking bench for urv_fetch_unit. A queue-based
// model of the instruction stream is compared against the DUT on every
// negative clock edge; directed sequences pin the model with literal values
// and a randomized phase mixes stalls, kills and memory wait states.
module tb_urv_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        f_stall_i = 1'b0;
  logic        f_kill_i = 1'b0;
  logic [31:0] f_bra_target_i = 32'h0;
  logic [31:0] im_addr_o;
  logic        im_rd_o;
  logic [31:0] im_data_i = 32'h0;
  logic        im_valid_i = 1'b0;
  logic [31:0] f_ir_o;
  logic [31:0] f_pc_o;
  logic        f_valid_o;

  urv_fetch_unit #(.RESET_VECTOR(RV)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .f_stall_i      (f_stall_i),
    .f_kill_i       (f_kill_i),
    .f_bra_target_i (f_bra_target_i),
    .im_addr_o      (im_addr_o),
    .im_rd_o        (im_rd_o),
    .im_data_i      (im_data_i),
    .im_valid_i     (im_valid_i),
    .f_ir_o         (f_ir_o),
    .f_pc_o         (f_pc_o),
    .f_valid_o      (f_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Memory contents: word at address a is a ^ key.
  logic [31:0] key = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } instr_t;

  // Behavioural model: fetched-but-undelivered instructions in order, the
  // instruction on display, and the next address the stream still needs.
  instr_t      m_q[$];
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [31:0] m_fetch;
  bit          m_inflight;

  // Memory side: request sampled at the last edge, answered this cycle.
  bit          mem_req;
  logic [31:0] mem_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs; the memory answers the previously sampled
  // request, and when idle may still wiggle im_valid_i with junk data.
  task automatic apply(input bit stall, input bit kill, input logic [31:0] tgt, input bit ok);
    f_stall_i      = stall;
    f_kill_i       = kill;
    f_bra_target_i = tgt;
    im_valid_i     = ok;
    im_data_i      = mem_req ? (mem_addr ^ key) : ($urandom() | 32'h8000_0001);
  endtask

  task automatic step(input bit stall, input bit kill, input logic [31:0] tgt, input bit ok);
    @(posedge clk_i);
    #1;
    apply(stall, kill, tgt, ok);
    @(negedge clk_i);
    #1;
  endtask

  // Compare process: check outputs against the model, then advance it.
  bit          e_rd;
  bit          e_got;
  logic [31:0] e_addr;
  instr_t      e_item;

  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        m_q.delete();
        m_valid    = 1'b0;
        m_fetch    = RV;
        m_inflight = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = 32'h0;
      end else begin
        check_b("f_valid", f_valid_o, m_valid);
        if (m_valid) begin
          check("f_pc", f_pc_o, m_pc);
          check("f_ir", f_ir_o, m_ir);
        end
        e_rd = f_kill_i || !f_stall_i || (!m_inflight && m_q.size() == 0);
        check_b("im_rd", im_rd_o, e_rd);
        e_got = m_inflight && im_valid_i && !f_kill_i;
        if (f_kill_i) e_addr = f_bra_target_i & 32'hFFFF_FFFC;
        else          e_addr = e_got ? m_fetch + 32'd4 : m_fetch;
        if (e_rd) check("im_addr", im_addr_o, e_addr);

        if (f_kill_i) begin
          m_q.delete();
          m_valid = 1'b0;
          m_fetch = f_bra_target_i & 32'hFFFF_FFFC;
        end else begin
          if (e_got) begin
            m_q.push_back('{pc: m_fetch, ir: m_fetch ^ key});
            m_fetch = m_fetch + 32'd4;
          end
          if (!f_stall_i) begin
            if (m_q.size() != 0) begin
              e_item  = m_q.pop_front();
              m_pc    = e_item.pc;
              m_ir    = e_item.ir;
              m_valid = 1'b1;
            end else begin
              m_valid = 1'b0;
            end
          end
        end
        m_inflight = e_rd;
        mem_req    = im_rd_o;
        mem_addr   = im_addr_o;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check_b("rst_valid", f_valid_o, 1'b0);
    check("rst_ir", f_ir_o, 32'h0000_0013);
    check("rst_pc", f_pc_o, 32'h0);

    // Reset release, zero-wait memory, data = addr.
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    apply(0, 0, 32'h0, 1);
    @(negedge clk_i);
    #1;
    check_b("boot_rd", im_rd_o, 1'b1);
    check("boot_addr", im_addr_o, 32'h0);
    check_b("boot_valid", f_valid_o, 1'b0);
    step(0, 0, 32'h0, 1);
    check("c1_addr", im_addr_o, 32'h4);
    check_b("c1_valid", f_valid_o, 1'b0);
    step(0, 0, 32'h0, 1);
    check_b("c2_valid", f_valid_o, 1'b1);
    check("c2_pc", f_pc_o, 32'h0);
    check("c2_ir", f_ir_o, 32'h0);
    check("c2_addr", im_addr_o, 32'h8);
    step(0, 0, 32'h0, 1);
    check("c3_pc", f_pc_o, 32'h4);
    check("c3_ir", f_ir_o, 32'h4);
    step(0, 0, 32'h0, 1);
    check("c4_pc", f_pc_o, 32'h8);
    step(0, 0, 32'h0, 1);
    check("c5_pc", f_pc_o, 32'hC);

    // Stall for three cycles while 0x10 is on display.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 32'h0, 1);
      check("stall_pc", f_pc_o, 32'h10);
      check_b("stall_valid", f_valid_o, 1'b1);
      check_b("stall_rd", im_rd_o, 1'b0);
    end
    step(0, 0, 32'h0, 1);
    check("rel_pc", f_pc_o, 32'h10);
    check("rel_addr", im_addr_o, 32'h18);
    step(0, 0, 32'h0, 1);
    check("skid_pc", f_pc_o, 32'h14);
    check_b("skid_valid", f_valid_o, 1'b1);
    step(0, 0, 32'h0, 1);
    check("after_skid_pc", f_pc_o, 32'h18);
    check_b("after_skid_valid", f_valid_o, 1'b1);
    check("req20_addr", im_addr_o, 32'h20);

    // Two wait states on the request for 0x20.
    step(0, 0, 32'h0, 0);
    check("retry1_addr", im_addr_o, 32'h20);
    check("retry1_pc", f_pc_o, 32'h1C);
    step(0, 0, 32'h0, 0);
    check("retry2_addr", im_addr_o, 32'h20);
    check_b("bubble1", f_valid_o, 1'b0);
    step(0, 0, 32'h0, 1);
    check_b("bubble2", f_valid_o, 1'b0);
    check("post_retry_addr", im_addr_o, 32'h24);
    step(0, 0, 32'h0, 1);
    check("retry_pc", f_pc_o, 32'h20);
    check("retry_ir", f_ir_o, 32'h20);

    // Kill to 0x100 while 0x30 is in flight.
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 1);
    check("req30_addr", im_addr_o, 32'h30);
    step(0, 1, 32'h100, 1);
    check("kill_addr", im_addr_o, 32'h100);
    check_b("kill_rd", im_rd_o, 1'b1);
    step(0, 0, 32'h0, 1);
    check_b("kill_flush", f_valid_o, 1'b0);
    step(1, 0, 32'h0, 1);
    check_b("kill_tgt_valid", f_valid_o, 1'b1);
    check("kill_tgt_pc", f_pc_o, 32'h100);

    // Kill to 0x200 during a stall with the skid full.
    step(1, 0, 32'h0, 1);
    check_b("hold_rd", im_rd_o, 1'b0);
    step(1, 1, 32'h200, 1);
    check("kill2_addr", im_addr_o, 32'h200);
    check_b("kill2_rd", im_rd_o, 1'b1);
    step(0, 0, 32'h0, 1);
    check_b("kill2_flush", f_valid_o, 1'b0);
    step(0, 0, 32'h0, 1);
    check_b("kill2_valid", f_valid_o, 1'b1);
    check("kill2_pc", f_pc_o, 32'h200);

    // Address wrap-around; target low bits must be ignored.
    step(0, 1, 32'hFFFF_FFFB, 1);
    check("wrap_kill_addr", im_addr_o, 32'hFFFF_FFF8);
    step(0, 0, 32'h0, 1);
    check("wrap_addr_fc", im_addr_o, 32'hFFFF_FFFC);
    step(0, 0, 32'h0, 1);
    check("wrap_addr_0", im_addr_o, 32'h0);
    check("wrap_pc_f8", f_pc_o, 32'hFFFF_FFF8);
    step(0, 0, 32'h0, 1);
    check("wrap_pc_fc", f_pc_o, 32'hFFFF_FFFC);
    step(0, 0, 32'h0, 1);
    check("wrap_pc_0", f_pc_o, 32'h0);
    check("wrap_ir_0", f_ir_o, 32'h0);

    // Asynchronous reset mid-cycle with a response pending.
    @(posedge clk_i);
    #1;
    apply(0, 0, 32'h0, 1);
    #2;
    rst_n_i = 1'b0;
    #1;
    check_b("async_valid", f_valid_o, 1'b0);
    check("async_pc", f_pc_o, 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    apply(0, 0, 32'h0, 1);
    @(negedge clk_i);
    #1;
    check("reboot_addr", im_addr_o, RV);
    check_b("reboot_valid", f_valid_o, 1'b0);
    step(0, 0, 32'h0, 1);
    check_b("stale_ignored", f_valid_o, 1'b0);
    check("reboot_addr4", im_addr_o, 32'h4);
    step(0, 0, 32'h0, 1);
    check_b("reboot_first_valid", f_valid_o, 1'b1);
    check("reboot_first_pc", f_pc_o, RV);

    // Randomized traffic checked by the model alone.
    key = $urandom();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(3) == 0), ($urandom_range(19) == 0), $urandom(),
           ($urandom_range(4) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
